// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin arbiter granting two requesters access to a single-port FIFO.
// Optional macro FIFO_ARB_STATS_EN adds a saturating stall_cnt output.
module fifo_arbiter #(
    parameter int DEPTH = 8,
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_rw,
    input  logic [2*DW-1:0]         req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DW-1:0]           rsp_data,
    output logic                    fifo_en,
    output logic                    fifo_r_w,
    output logic [DW-1:0]           fifo_in,
    input  logic [DW-1:0]           fifo_out,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]             stall_cnt,
`endif
    output logic                    fifo_reset
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, RD_RSP} state_t;
    state_t state;
    logic last, gnt, pick, acc;
    logic [1:0] elig;
    logic [DW-1:0] wsel;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rsp_data = fifo_out;
    always_comb begin
        elig = req_valid & ((req_rw & {2{!full}}) | (~req_rw & {2{!empty}}));
        // with both eligible, favour whoever was not granted last
        pick = (&elig) ? !last : elig[1];
        acc = state == IDLE && !fifo_reset && |elig;
        req_ready = acc ? (pick ? 2'b10 : 2'b01) : 2'b00;
        wsel = pick ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            last <= 1'b1;
            gnt <= 1'b0;
            fifo_en <= 1'b0;
            fifo_r_w <= 1'b0;
            fifo_in <= '0;
            rsp_valid <= 2'b00;
            fifo_reset <= 1'b1;
        end else begin
            fifo_reset <= 1'b0;
            fifo_en <= 1'b0;
            rsp_valid <= 2'b00;
            case (state)
                IDLE: if (acc) begin
                    fifo_en <= 1'b1;
                    fifo_r_w <= req_rw[pick];
                    fifo_in <= wsel;
                    last <= pick;
                    gnt <= pick;
                    count <= req_rw[pick] ? count + 1'b1 : count - 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    state <= fifo_r_w ? IDLE : RD_RSP;
                    rsp_valid <= fifo_r_w ? 2'b00 : (gnt ? 2'b10 : 2'b01);
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (|req_valid && !acc && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbiter and an emulated FIFO.
module tb_fifo_arbiter;
    localparam int DEPTH = 8;
    localparam int DW = 32;
    logic clk = 0, reset_n = 0;
    logic [1:0] req_valid = 0, req_rw = 0, req_ready, rsp_valid;
    logic [2*DW-1:0] req_wdata = 0;
    logic [DW-1:0] rsp_data, fifo_in, fifo_out = 0;
    logic fifo_en, fifo_r_w, fifo_reset, full, empty;
    logic [3:0] count;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif
    int errors = 0, checks = 0;
    logic [DW-1:0] fq[$];

    fifo_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rw(req_rw),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .fifo_en(fifo_en), .fifo_r_w(fifo_r_w), .fifo_in(fifo_in),
        .fifo_out(fifo_out), .count(count), .full(full), .empty(empty),
`ifdef FIFO_ARB_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .fifo_reset(fifo_reset));

    always #5 clk = ~clk;

    // Emulated FIFO with registered read data
    always @(posedge clk) begin
        if (fifo_reset) begin
            fq.delete();
            fifo_out <= '0;
        end else if (fifo_en) begin
            if (fifo_r_w) fq.push_back(fifo_in);
            else if (fq.size() > 0) fifo_out <= fq.pop_front();
        end
    end

    task automatic do_reset();
        req_valid = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        req_valid = 2'b11; req_rw = 2'b11; reset_n = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL rst_fifo_en got=%b exp=0", fifo_en); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_count got=%0d/%b/%b exp=0/1/0", count, empty, full); end
        checks++; if (fifo_reset !== 1'b1) begin errors++; $display("FAIL rst_fifo_reset got=%b exp=1", fifo_reset); end
        @(negedge clk); reset_n = 1; #1;
        checks++; if (fifo_reset !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL rel_cycle got fifo_reset=%b ready=%b exp 1/00", fifo_reset, req_ready); end
        @(posedge clk); #1;
        checks++; if (fifo_reset !== 1'b0 || fifo_en !== 1'b0) begin errors++; $display("FAIL rel_clear got fifo_reset=%b fifo_en=%b exp 0/0", fifo_reset, fifo_en); end
        req_valid = 0;
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_rw = 2'b01; req_wdata[DW-1:0] = 32'hA5A5_0001; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
        @(negedge clk); req_valid = 0; #1;
        checks++; if ({fifo_en, fifo_r_w} !== 2'b11 || fifo_in !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_issue got en/rw=%b in=%h exp 11/a5a50001", {fifo_en, fifo_r_w}, fifo_in); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL wr_count got=%0d exp=1", count); end
        @(negedge clk); #1;
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL wr_en_drop got=%b exp=0", fifo_en); end
    endtask

    task automatic test_write_read();
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_rw = 2'b01; req_wdata[DW-1:0] = 32'h11;
        @(negedge clk); req_valid = 0;
        @(negedge clk); req_valid = 2'b10; req_rw = 2'b00; #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready got=%b exp=10", req_ready); end
        @(negedge clk); req_valid = 0; #1;
        checks++; if ({fifo_en, fifo_r_w} !== 2'b10 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_issue got en/rw=%b rsp=%b exp 10/00", {fifo_en, fifo_r_w}, rsp_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rd_count got=%0d exp=0", count); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h11) begin errors++; $display("FAIL rd_rsp got=%b/%h exp 10/00000011", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_once got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp;
        do_reset();
        @(negedge clk); req_valid = 2'b11; req_rw = 2'b11; req_wdata = {$urandom, $urandom};
        for (int k = 0; k < 20; k++) begin
            #1;
            exp = (k < 16 && k % 2 == 0) ? (((k / 2) % 2) ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL alt_ready k=%0d got=%b exp=%b", k, req_ready, exp); end
            @(negedge clk);
        end
        #1;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL alt_full got=%0d/%b exp 8/1", count, full); end
        req_valid = 0;
    endtask

    task automatic test_empty_read();
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_rw = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready k=%0d got=%b exp=00", k, req_ready); end
            @(negedge clk);
        end
        req_valid = 2'b11; req_rw = 2'b10; req_wdata[2*DW-1:DW] = 32'h77; #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_wr_first got=%b exp=10", req_ready); end
        @(negedge clk); req_valid = 2'b01; #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_issue got=%b exp=00", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b01 || count !== 4'd1) begin errors++; $display("FAIL stall_rd_acc got=%b/%0d exp 01/1", req_ready, count); end
        @(negedge clk); req_valid = 0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h77 || count !== 4'd0) begin errors++; $display("FAIL stall_rsp got=%b/%h/%0d exp 01/00000077/0", rsp_valid, rsp_data, count); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_rw = 2'b01; req_wdata[DW-1:0] = 32'h55;
        @(negedge clk); req_valid = 0;
        @(negedge clk); req_valid = 2'b01; req_rw = 2'b00;
        @(negedge clk); req_valid = 0; #1;
        checks++; if ({fifo_en, fifo_r_w} !== 2'b10) begin errors++; $display("FAIL mid_issue got=%b exp=10", {fifo_en, fifo_r_w}); end
        #1 reset_n = 0; #1;
        checks++; if (fifo_en !== 1'b0 || count !== 4'd0 || fifo_reset !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_async got en=%b cnt=%0d frst=%b rsp=%b exp 0/0/1/00", fifo_en, count, fifo_reset, rsp_valid); end
        @(negedge clk); reset_n = 1; #1;
        checks++; if (fifo_reset !== 1'b1) begin errors++; $display("FAIL mid_frst_hold got=%b exp=1", fifo_reset); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 2'b00 || fifo_reset !== 1'b0) begin errors++; $display("FAIL mid_after k=%0d got rsp=%b frst=%b exp 00/0", k, rsp_valid, fifo_reset); end
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_rw = 2'b00;
        repeat (10) @(negedge clk);
        req_valid = 0; #1;
        checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_cnt got=%0d exp=10", stall_cnt); end
    endtask
`endif

    // Transaction-level model: cycles until the arbiter is free, occupancy, last winner, stored data
    task automatic test_random();
        int busy = 0, cnt = 0, g;
        bit last = 1, el0, el1, e_en = 0, e_rw = 0;
        logic [DW-1:0] e_d = 0, r1d = 0, rnd = 0, dat;
        logic [1:0] er, acc = 0, r1 = 0, rn = 0;
        logic [DW-1:0] mq[$];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !acc[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = $urandom_range(3) != 0;
                    req_rw[i] = 1'($urandom_range(1));
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
            #1;
            el0 = req_valid[0] && (req_rw[0] ? cnt < DEPTH : cnt > 0);
            el1 = req_valid[1] && (req_rw[1] ? cnt < DEPTH : cnt > 0);
            g = (el0 && el1) ? (last ? 0 : 1) : (el1 ? 1 : 0);
            er = (busy == 0 && (el0 || el1)) ? 2'(1 << g) : 2'b00;
            checks++; if (req_ready !== er) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            checks++; if (fifo_en !== e_en) begin errors++; $display("FAIL rnd_en c=%0d got=%b exp=%b", c, fifo_en, e_en); end
            if (e_en) begin
                checks++; if (fifo_r_w !== e_rw || (e_rw && fifo_in !== e_d)) begin errors++; $display("FAIL rnd_op c=%0d got=%b/%h exp=%b/%h", c, fifo_r_w, fifo_in, e_rw, e_d); end
            end
            checks++; if (rsp_valid !== rn) begin errors++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, rsp_valid, rn); end
            if (rn != 0) begin
                checks++; if (rsp_data !== rnd) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rsp_data, rnd); end
            end
            checks++; if (count !== 4'(cnt) || full !== (cnt == DEPTH) || empty !== (cnt == 0)) begin errors++; $display("FAIL rnd_count c=%0d got=%0d/%b/%b exp=%0d", c, count, full, empty, cnt); end
            rn = r1; rnd = r1d; r1 = 0; e_en = 0;
            busy = busy > 0 ? busy - 1 : 0;
            if (er != 0) begin
                dat = req_wdata[g*DW +: DW];
                last = g[0]; e_en = 1; e_rw = req_rw[g]; e_d = dat;
                if (e_rw) begin cnt++; mq.push_back(dat); busy = 1; end
                else begin cnt--; r1 = er; r1d = mq.pop_front(); busy = 2; end
            end
            acc = er;
        end
        req_valid = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_read();
        test_alternate();
        test_empty_read();
        test_reset_mid_read();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
